// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, combinational instruction-memory addressing, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module fetch_stage #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_a,
  input  logic [31:0]       imem_rd,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [31:0]       fetch_pc_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       pc_plus4_o,
  output logic [31:0]       instr_o,
  output logic              valid_o,
  output logic              halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // First byte address past the end of instruction memory (33 bits so it never wraps).
  localparam logic [32:0] LIMIT = 33'd1 << (ADDR_W + 2);

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, pc_plus4;
  logic [31:0] id_pc, id_pc_nx;
  logic [31:0] id_pc4, id_pc4_nx;
  logic [31:0] id_instr, id_instr_nx;
  logic        id_valid, id_valid_nx;
  logic        redir_bad, adv_bad;

  assign pc_plus4  = pc + 32'd4;
  assign redir_bad = (redirect_pc_i[1:0] != 2'b00) || ({1'b0, redirect_pc_i} >= LIMIT);
  assign adv_bad   = ({1'b0, pc_plus4} >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_instr <= '0;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      id_pc    <= id_pc_nx;
      id_pc4   <= id_pc4_nx;
      id_instr <= id_instr_nx;
      id_valid <= id_valid_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    id_pc_nx    = id_pc;
    id_pc4_nx   = id_pc4;
    id_instr_nx = id_instr;
    id_valid_nx = id_valid;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (redirect_i) begin
          id_pc_nx    = '0;
          id_pc4_nx   = '0;
          id_instr_nx = '0;
          id_valid_nx = 1'b0;
          if (redir_bad) state_nx = HALT;
          else           pc_nx    = redirect_pc_i;
        end else if (!stall_i) begin
          // The word at pc is still captured on the edge that runs off the end.
          id_pc_nx    = pc;
          id_pc4_nx   = pc_plus4;
          id_instr_nx = imem_rd;
          id_valid_nx = 1'b1;
          if (adv_bad) state_nx = HALT;
          else         pc_nx    = pc_plus4;
        end
      end
      HALT: begin
        id_pc_nx    = '0;
        id_pc4_nx   = '0;
        id_instr_nx = '0;
        id_valid_nx = 1'b0;
      end
      default: state_nx = BOOT;
    endcase
  end

  assign imem_a     = pc[ADDR_W+1:2];
  assign fetch_pc_o = pc;
  assign pc_o       = id_pc;
  assign pc_plus4_o = id_pc4;
  assign instr_o    = id_instr;
  assign valid_o    = id_valid;
  assign halted_o   = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, bubble_inc;

  always_comb begin
    fetch_inc  = (state == RUN) && !redirect_i && !stall_i;
    bubble_inc = (state == RUN) && (redirect_i || stall_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (fetch_inc)  fetch_cnt_o  <= fetch_cnt_o + 32'd1;
      if (bubble_inc) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts each edge, a monitor compares.
// Honours FETCH_PERF_CNT_EN when the design is built with it.
module tb_fetch_stage;

  localparam int          AW    = 6;
  localparam int          DEPTH = 64;
  localparam longint      LIM   = 4 * DEPTH;

  logic              clk, rst_n;
  logic [AW-1:0]     imem_a;
  logic [31:0]       imem_rd;
  logic              stall_i, redirect_i;
  logic [31:0]       redirect_pc_i;
  logic [31:0]       fetch_pc_o, pc_o, pc_plus4_o, instr_o;
  logic              valid_o, halted_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       fetch_cnt_o, bubble_cnt_o;
`endif

  logic [31:0] mem [DEPTH];
  assign imem_rd = mem[imem_a];

  fetch_stage #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_a(imem_a), .imem_rd(imem_rd),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fetch_pc_o(fetch_pc_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .instr_o(instr_o), .valid_o(valid_o), .halted_o(halted_o)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] fpc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic [AW-1:0] ia;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc;
    logic [31:0] bc;
`endif
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: phase 0 = just out of reset, 1 = fetching, 2 = stopped.
  int          m_phase;
  logic [31:0] m_pc, m_if_pc, m_if_pc4, m_instr;
  logic        m_valid;
  logic [31:0] m_fc, m_bc;
  int          halt_age;

  function automatic obs_t sample();
    obs_t o;
    o.fpc = fetch_pc_o; o.pc = pc_o; o.pc4 = pc_plus4_o; o.instr = instr_o;
    o.valid = valid_o; o.halted = halted_o; o.ia = imem_a;
`ifdef FETCH_PERF_CNT_EN
    o.fc = fetch_cnt_o; o.bc = bubble_cnt_o;
`endif
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.fpc = m_pc; o.pc = m_if_pc; o.pc4 = m_if_pc4; o.instr = m_instr;
    o.valid = m_valid; o.halted = (m_phase == 2);
    o.ia = AW'((m_pc / 4) % DEPTH);
`ifdef FETCH_PERF_CNT_EN
    o.fc = m_fc; o.bc = m_bc;
`endif
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t: got fpc=%h pc=%h pc4=%h instr=%h v=%b h=%b ia=%0d, expected fpc=%h pc=%h pc4=%h instr=%h v=%b h=%b ia=%0d",
                  name, $time, act.fpc, act.pc, act.pc4, act.instr, act.valid, act.halted, act.ia,
                  exp.fpc, exp.pc, exp.pc4, exp.instr, exp.valid, exp.halted, exp.ia);
`ifdef FETCH_PERF_CNT_EN
    if (act !== exp && (act.fc !== exp.fc || act.bc !== exp.bc))
      $display("  counters got fetch=%0d bubble=%0d, expected fetch=%0d bubble=%0d", act.fc, act.bc, exp.fc, exp.bc);
`endif
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = 32'h0; m_if_pc = '0; m_if_pc4 = '0; m_instr = '0;
    m_valid = 1'b0; m_fc = '0; m_bc = '0; halt_age = 0;
  endtask

  task automatic bubble();
    m_if_pc = '0; m_if_pc4 = '0; m_instr = '0; m_valid = 1'b0;
  endtask

  // Predict the outcome of the coming clock edge and queue it for the monitor.
  task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] nxt;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 2) begin
      bubble();
      halt_age++;
    end else if (rd) begin
      bubble();
      m_bc++;
      if ((rpc % 4) != 0 || longint'(rpc) >= LIM) m_phase = 2;
      else m_pc = rpc;
    end else if (st) begin
      m_bc++;
    end else begin
      nxt = m_pc + 32'd4;
      m_if_pc = m_pc; m_if_pc4 = nxt; m_instr = mem[(m_pc / 4) % DEPTH]; m_valid = 1'b1;
      m_fc++;
      if (longint'(nxt) >= LIM) m_phase = 2;
      else m_pc = nxt;
    end
    exp_q.push_back(model_obs());
  endtask

  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    model_step(st, rd, rpc);
  endtask

  task automatic reset_pulse();
    obs_t r;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    r = model_obs();
    check_obs("reset_async", sample(), r);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    model_step(1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: compare each predicted edge just after the DUT takes it.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_obs("edge", sample(), e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    int r;
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h20020005; mem[1] = 32'h20020005; mem[2] = 32'h2003000c;
    mem[3] = 32'h2067fff7; mem[17] = 32'h20020001;

    // Reset, then interrupt the sequential fetch mid-run and restart it.
    reset_pulse();
    cycle(0, 0, 0); cycle(0, 0, 0);
    reset_pulse();

    // Sequential fetch, stall, redirect combined with stall.
    repeat (3) cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 1, 32'h44);
    repeat (3) cycle(0, 0, 0);

    // Misaligned redirect halts; later stalls and redirects are ignored.
    cycle(0, 1, 32'h42);
    for (int i = 0; i < 10; i++) cycle(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(63) * 4);

    // Run off the end of memory.
    reset_pulse();
    cycle(0, 1, 32'hFC);
    repeat (3) cycle(0, 0, 0);

    // Out-of-range aligned redirect.
    reset_pulse();
    cycle(0, 0, 0);
    cycle(0, 1, 32'h100);
    cycle(0, 0, 0);

    // Randomised traffic.
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      if (m_phase == 2 && halt_age > 3) reset_pulse();
      r = $urandom_range(99);
      case ($urandom_range(9))
        0:       rpc = ($urandom_range(63) * 4) | 32'($urandom_range(3, 1));
        1:       rpc = $urandom;
        default: rpc = $urandom_range(63) * 4;
      endcase
      cycle(r < 25, r >= 88, rpc);
    end

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the MIPS pipeline, directly upstream of the instruction memory. Holds the program counter and drives the combinational word address into instruction memory. Captures the returned word into the IF/ID pipeline register with its PC and PC+4. Handles stall, branch/jump redirect, and a fatal-halt condition for out-of-range or misaligned fetch.

Parameters:
ADDR_W, 6, instruction-memory word-address width (depth = 2**ADDR_W words)
RESET_PC, 32'h00000000, PC value loaded on reset (byte address, word aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_a  output  ADDR_W  word address to instruction memory = pc[ADDR_W+1:2], combinational from pc
imem_rd  input  32  instruction word returned combinationally by instruction memory
stall_i  input  1  hazard unit: hold pc and IF/ID contents
redirect_i  input  1  branch taken / jump resolved downstream
redirect_pc_i  input  32  target byte address, valid when redirect_i=1
fetch_pc_o  output  32  current pc register
pc_o  output  32  PC of instruction held in IF/ID
pc_plus4_o  output  32  pc_o + 4, for branch/link computation
instr_o  output  32  instruction held in IF/ID (32'h0 = nop when bubble)
valid_o  output  1  IF/ID holds a real instruction
halted_o  output  1  fetch permanently stopped until reset

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, pc_o=0, pc_plus4_o=0, instr_o=0, valid_o=0, halted_o=0, state=BOOT.
- States: BOOT, RUN, HALT.
- BOOT: one cycle; IF/ID not loaded, pc not advanced. Always moves to RUN on the next edge.
- RUN, priority per edge: redirect_i > stall_i > normal.
- Normal: IF/ID <= {pc, pc+4, imem_rd, valid=1}; pc <= pc+4. Read latency: instruction appears on instr_o one edge after pc presents its address.
- Redirect: pc <= redirect_pc_i; IF/ID <= {0, 0, 32'h0, valid=0} (bubble). Applies even if stall_i=1 in the same cycle.
- Stall (no redirect): pc and IF/ID hold all values.
- Halt conditions, checked in RUN:
  - redirect_i=1 with redirect_pc_i[1:0]!=0 (misaligned).
  - Redirect target, or pc+4 on a normal advance, has byte address >= 4*2**ADDR_W (out of range; no wrap-around).
- On the halting edge, the instruction currently at pc is still captured normally; the redirect case instead loads a bubble. Then: state=HALT, halted_o=1, pc unchanged.
- HALT: IF/ID <= bubble on the first HALT edge, then holds. stall_i and redirect_i are ignored. Exit only by rst_n.
- imem_a is always pc[ADDR_W+1:2], including in BOOT and HALT. Upper pc bits are never used for addressing.
- Reset asserted mid-operation clears everything immediately, independent of clk. The first valid instruction follows two edges after deassertion (BOOT edge, then capture edge).
- All PC arithmetic is 32-bit, modulo 2**32. Range checking uses the full 32-bit value.

Optional Feature:
FETCH_PERF_CNT_EN
- When defined, adds outputs fetch_cnt_o[31:0] and bubble_cnt_o[31:0], both reset to 0.
- fetch_cnt_o increments on every edge where IF/ID loads valid=1.
- bubble_cnt_o increments on every edge in RUN where IF/ID loads valid=0 or stall_i holds.
- Both counters wrap at 2**32 and freeze in HALT.
- When undefined, the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
1. Sequential fetch: memory preloaded with the standard test program (words 0..2 = 20020005, 20020005, 2003000c); release reset. Required: valid_o=0 for the first edge, then instr_o=20020005/20020005/2003000c with pc_o=0/4/8 on consecutive edges; pc_plus4_o=4/8/C.
2. Stall: stall_i=1 for 3 cycles while instr_o=2003000c (pc_o=8). Required: instr_o, pc_o and fetch_pc_o=C hold; the next edge after release gives instr_o=2067fff7, pc_o=C.
3. Redirect: redirect_i=1 with redirect_pc_i=32'h44, asserted together with stall_i=1. Required: next edge valid_o=0, instr_o=0, fetch_pc_o=44; following edge instr_o=20020001, pc_o=44.
4. Misaligned redirect: redirect_pc_i=32'h42. Required: next edge halted_o=1, valid_o=0; further redirects and stalls have no effect for 10 cycles.
5. Fall-off end: redirect to 32'hFC with ADDR_W=6. Required: word 63 captured with pc_o=FC, valid_o=1; same edge halted_o=1; next edge valid_o=0.
6. Reset mid-run: assert rst_n=0 between edges during scenario 1. Required: all outputs are at reset values immediately; after release, the sequence of scenario 1 restarts from pc_o=0. With FETCH_PERF_CNT_EN, the counters read 0.
